// File: rtl/tile_lane_engine.sv
// Piano Tiles game core: a ring FIFO of falling tiles, key judging at the hit line,
// saturating BCD score with speed-up, and an IDLE/PLAY/OVER game FSM.
module tile_lane_engine #(
  parameter int NUM_LANES    = 4,
  parameter int NUM_TILES    = 4,
  parameter int Y_W          = 10,
  parameter int SCREEN_H     = 480,
  parameter int TILE_H       = 120,
  parameter int HIT_LINE     = 400,
  parameter int SPAWN_FRAMES = 60,
  parameter int BASE_SPEED   = 2,
  parameter int MAX_SPEED    = 8,
  parameter int SPEEDUP_HITS = 10,
  localparam int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_tick,
  input  logic                        start,
  input  logic [LANE_W-1:0]           rand_lane,
  input  logic                        key_valid,
  input  logic [LANE_W-1:0]           key_lane,
  output logic [NUM_TILES-1:0]        tile_valid,
  output logic [NUM_TILES*Y_W-1:0]    tile_y,
  output logic [NUM_TILES*LANE_W-1:0] tile_lane,
  output logic [3:0]                  score_tens,
  output logic [3:0]                  score_ones,
  output logic [3:0]                  speed,
  output logic                        playing,
  output logic                        game_over
);

  localparam int PTR_W = $clog2(NUM_TILES);
  localparam int CNT_W = PTR_W + 1;
  localparam int SPN_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam int HIT_W = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t state, state_n;
  logic playing_n, game_over_n, enter_play, commit;

  logic [Y_W-1:0]    y_q    [NUM_TILES];
  logic [LANE_W-1:0] lane_q [NUM_TILES];
  logic [Y_W-1:0]    y_n    [NUM_TILES];
  logic [LANE_W-1:0] lane_n [NUM_TILES];
  logic [NUM_TILES-1:0] valid_n;
  logic [PTR_W-1:0] head, tail, head_n, tail_n;
  logic [CNT_W-1:0] count, count_pop, count_n;
  logic [SPN_W-1:0] spawn_cnt, spawn_cnt_n;
  logic [HIT_W-1:0] hit_cnt, hit_cnt_n;
  logic [3:0] tens_n, ones_n, speed_n;
  logic [Y_W-1:0] head_y;
  logic [Y_W:0] head_sum;
  logic [LANE_W-1:0] spawn_lane;
  logic play_key, play_tick, hit, spawn, tick_miss, miss;

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_pack
    assign tile_y[g*Y_W +: Y_W]       = y_q[g];
    assign tile_lane[g*LANE_W +: LANE_W] = lane_q[g];
  end

  // State register; the status flags are registered alongside it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      playing   <= playing_n;
      game_over <= game_over_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: state_n = start ? ST_PLAY : ST_IDLE;
      ST_PLAY: state_n = miss ? ST_OVER : ST_PLAY;
      ST_OVER: state_n = start ? ST_PLAY : ST_OVER;
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM outputs: game (re)start strobe, datapath commit enable, next status flags.
  always_comb begin
    enter_play  = (state != ST_PLAY) && (state_n == ST_PLAY);
    commit      = (state == ST_PLAY) && !miss;
    playing_n   = (state_n == ST_PLAY);
    game_over_n = (state_n == ST_OVER);
  end

  // Judge against pre-move values, then pop, move survivors, and spawn into the tail.
  always_comb begin
    play_key   = key_valid && (state == ST_PLAY);
    play_tick  = frame_tick && (state == ST_PLAY);
    spawn_lane = LANE_W'(32'(rand_lane) % NUM_LANES);
    head_y     = y_q[head];
    head_sum   = {1'b0, head_y} + (Y_W+1)'(TILE_H);
    hit = play_key && (count != '0) && (lane_q[head] == key_lane) &&
          (head_y <= Y_W'(HIT_LINE)) && (head_sum > (Y_W+1)'(HIT_LINE));
    head_n    = hit ? head + PTR_W'(1) : head;
    count_pop = hit ? count - CNT_W'(1) : count;
    spawn     = play_tick && (spawn_cnt == '0) && (count_pop != CNT_W'(NUM_TILES));
    tail_n    = spawn ? tail + PTR_W'(1) : tail;
    count_n   = spawn ? count_pop + CNT_W'(1) : count_pop;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (spawn && (PTR_W'(i) == tail)) begin
        valid_n[i] = 1'b1;
        y_n[i]     = '0;
        lane_n[i]  = spawn_lane;
      end else begin
        valid_n[i] = tile_valid[i] && !(hit && (PTR_W'(i) == head));
        y_n[i]     = (play_tick && valid_n[i]) ? y_q[i] + Y_W'(speed) : y_q[i];
        lane_n[i]  = lane_q[i];
      end
    end
    // An empty FIFO after the pop means head_n is the (unmoved) spawn slot.
    tick_miss = play_tick && (count_pop != '0) && (y_n[head_n] >= Y_W'(SCREEN_H));
    miss      = (play_key && !hit) || tick_miss;

    if (play_tick) begin
      spawn_cnt_n = (spawn_cnt == '0) ? SPN_W'(SPAWN_FRAMES - 1) : spawn_cnt - SPN_W'(1);
    end else begin
      spawn_cnt_n = spawn_cnt;
    end

    tens_n    = score_tens;
    ones_n    = score_ones;
    hit_cnt_n = hit_cnt;
    speed_n   = speed;
    if (hit) begin
      if ((score_tens == 4'd9) && (score_ones == 4'd9)) begin
        ones_n = 4'd9;
      end else if (score_ones == 4'd9) begin
        ones_n = 4'd0;
        tens_n = score_tens + 4'd1;
      end else begin
        ones_n = score_ones + 4'd1;
      end
      if (hit_cnt == HIT_W'(SPEEDUP_HITS - 1)) begin
        hit_cnt_n = '0;
        speed_n   = (speed < 4'(MAX_SPEED)) ? speed + 4'd1 : speed;
      end else begin
        hit_cnt_n = hit_cnt + HIT_W'(1);
      end
    end else begin
      hit_cnt_n = hit_cnt;
    end
  end

  // Tile FIFO, score and speed registers; a miss cycle leaves everything frozen.
  always_ff @(posedge Clk) begin
    if (Reset || enter_play) begin
      tile_valid <= '0;
      for (int i = 0; i < NUM_TILES; i++) begin
        y_q[i]    <= '0;
        lane_q[i] <= '0;
      end
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      score_tens <= 4'd0;
      score_ones <= 4'd0;
      speed      <= 4'(BASE_SPEED);
      spawn_cnt  <= '0;
      hit_cnt    <= '0;
    end else if (commit) begin
      tile_valid <= valid_n;
      for (int i = 0; i < NUM_TILES; i++) begin
        y_q[i]    <= y_n[i];
        lane_q[i] <= lane_n[i];
      end
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
      score_tens <= tens_n;
      score_ones <= ones_n;
      speed      <= speed_n;
      spawn_cnt  <= spawn_cnt_n;
      hit_cnt    <= hit_cnt_n;
    end
  end

endmodule

// File: tb/tb_tile_lane_engine.sv
// Bench for tile_lane_engine: directed game scenarios plus random play, checked against a
// queue-based game model. A second instance with SPAWN_FRAMES=1 exercises a full FIFO.
module tb_tile_lane_engine;
  localparam int NL = 4;
  localparam int NT = 4;
  localparam int YW = 10;
  localparam int LW = 2;

  logic Clk, Reset, frame_tick, start, key_valid;
  logic [LW-1:0] rand_lane, key_lane;
  logic [NT-1:0] d_tv, f_tv, c_tv;
  logic [NT*YW-1:0] d_ty, f_ty, c_ty;
  logic [NT*LW-1:0] d_tl, f_tl, c_tl;
  logic [3:0] d_st, d_so, d_sp, f_st, f_so, f_sp, c_st, c_so, c_sp;
  logic d_pl, d_go, f_pl, f_go, c_pl, c_go;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int sf = 60;

  // Model: the live tiles oldest-first, plus the physical slot of the oldest one.
  int ms, mhead, mscore, mspeed, mhit, mspawn;
  int qy[$];
  int ql[$];

  tile_lane_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start), .rand_lane(rand_lane),
    .key_valid(key_valid), .key_lane(key_lane), .tile_valid(d_tv), .tile_y(d_ty), .tile_lane(d_tl),
    .score_tens(d_st), .score_ones(d_so), .speed(d_sp), .playing(d_pl), .game_over(d_go));

  tile_lane_engine #(.SPAWN_FRAMES(1)) dut_f (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start), .rand_lane(rand_lane),
    .key_valid(key_valid), .key_lane(key_lane), .tile_valid(f_tv), .tile_y(f_ty), .tile_lane(f_tl),
    .score_tens(f_st), .score_ones(f_so), .speed(f_sp), .playing(f_pl), .game_over(f_go));

  assign c_tv = (sel == 1) ? f_tv : d_tv;
  assign c_ty = (sel == 1) ? f_ty : d_ty;
  assign c_tl = (sel == 1) ? f_tl : d_tl;
  assign c_st = (sel == 1) ? f_st : d_st;
  assign c_so = (sel == 1) ? f_so : d_so;
  assign c_sp = (sel == 1) ? f_sp : d_sp;
  assign c_pl = (sel == 1) ? f_pl : d_pl;
  assign c_go = (sel == 1) ? f_go : d_go;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hittable(input int lane);
    return (qy.size() > 0) && (ql[0] == lane) && (qy[0] <= 400) && (qy[0] + 120 > 400);
  endfunction

  task automatic model_clear();
    qy.delete();
    ql.delete();
    mhead = 0; mscore = 0; mspeed = 2; mhit = 0; mspawn = 0;
  endtask

  task automatic model_step();
    int nqy[$];
    int nql[$];
    int nh, nspawn;
    bit hit, miss;
    if (Reset) begin
      ms = 0;
      model_clear();
      return;
    end
    if (ms != 1) begin
      if (start) begin
        ms = 1;
        model_clear();
      end
      return;
    end
    hit = 0; miss = 0;
    nqy = qy; nql = ql; nh = mhead; nspawn = mspawn;
    if (key_valid) begin
      if (hittable(int'(key_lane))) begin
        hit = 1;
        void'(nqy.pop_front());
        void'(nql.pop_front());
        nh = (mhead + 1) % NT;
      end else begin
        miss = 1;
      end
    end
    if (frame_tick) begin
      foreach (nqy[k]) nqy[k] = nqy[k] + mspeed;
      if (nqy.size() > 0 && nqy[0] >= 480) miss = 1;
      if (mspawn == 0) begin
        if (nqy.size() < NT) begin
          nqy.push_back(0);
          nql.push_back(int'(rand_lane) % NL);
        end
        nspawn = sf - 1;
      end else begin
        nspawn = mspawn - 1;
      end
    end
    if (miss) begin
      ms = 2;
      return;
    end
    qy = nqy; ql = nql; mhead = nh; mspawn = nspawn;
    if (hit) begin
      if (mscore < 99) mscore++;
      mhit++;
      if (mhit == 10) begin
        mhit = 0;
        if (mspeed < 8) mspeed++;
      end
    end
  endtask

  task automatic check_all();
    for (int s = 0; s < NT; s++) begin
      int k;
      bit v;
      k = (s - mhead + NT) % NT;
      v = (k < qy.size());
      chk($sformatf("valid%0d", s), c_tv[s], v);
      if (v) begin
        chk($sformatf("y%0d", s), c_ty[s*YW +: YW], qy[k]);
        chk($sformatf("lane%0d", s), c_tl[s*LW +: LW], ql[k]);
      end
    end
    chk("tens", c_st, mscore / 10);
    chk("ones", c_so, mscore % 10);
    chk("speed", c_sp, mspeed);
    chk("playing", c_pl, ms == 1);
    chk("game_over", c_go, ms == 2);
  endtask

  task automatic tick_cycle();
    model_step();
    @(posedge Clk);
    #1;
    frame_tick = 1'b0; start = 1'b0; key_valid = 1'b0; Reset = 1'b0;
    check_all();
  endtask

  task automatic press(input int lane);
    key_valid = 1'b1;
    key_lane  = LW'(lane);
  endtask

  task automatic tick_until(input int target);
    int n;
    n = 0;
    while ((qy.size() == 0 || qy[0] != target) && n < 400 && ms == 1) begin
      frame_tick = 1'b1;
      tick_cycle();
      n++;
    end
    chk("reach_y", c_ty[mhead*YW +: YW], target);
  endtask

  task automatic restart();
    start = 1'b1;
    tick_cycle();
  endtask

  initial begin
    int slot, ysave, hits, n;
    Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; key_valid = 1'b0;
    rand_lane = '0; key_lane = '0;
    tick_cycle();
    chk("rst_speed", c_sp, 2);
    chk("rst_playing", c_pl, 0);
    chk("rst_valid", c_tv, 0);

    // First tick spawns at y=0; two more ticks bring it to y=4.
    rand_lane = 2'd3;
    restart();
    frame_tick = 1'b1;
    tick_cycle();
    chk("spawn_lane", c_tl[LW-1:0], 3);
    chk("spawn_y", c_ty[YW-1:0], 0);
    repeat (2) begin frame_tick = 1'b1; tick_cycle(); end
    chk("t1_y", c_ty[YW-1:0], 4);
    chk("t1_count", c_tv, 4'b0001);
    chk("t1_playing", c_pl, 1);

    tick_until(300);
    press(ql[0]);
    tick_cycle();
    chk("hit_slot", c_tv[0], 0);
    chk("hit_score", c_so, 1);
    chk("hit_playing", c_pl, 1);

    // Correct lane but head outside the window; tiles and score then stay frozen.
    slot = mhead; ysave = qy[0];
    press(ql[0]);
    tick_cycle();
    chk("early_over", c_go, 1);
    frame_tick = 1'b1; press(0);
    tick_cycle();
    chk("frozen_y", c_ty[slot*YW +: YW], ysave);
    chk("frozen_score", c_so, 1);

    restart();
    tick_until(300);
    press((ql[0] + 1) % NL);
    tick_cycle();
    chk("wrong_lane_over", c_go, 1);

    restart();
    press(0);
    tick_cycle();
    chk("empty_over", c_go, 1);

    restart();
    tick_until(280);
    press(ql[0]);
    tick_cycle();
    chk("edge280_over", c_go, 1);

    // y=400 is still inside the window even though this tick would move it past.
    restart();
    tick_until(400);
    press(ql[0]); frame_tick = 1'b1;
    tick_cycle();
    chk("edge400_score", c_so, 1);
    chk("edge400_playing", c_pl, 1);

    n = 0;
    while (c_go !== 1'b1 && n < 400) begin frame_tick = 1'b1; tick_cycle(); n++; end
    chk("falloff_over", c_go, 1);
    restart();
    chk("restart_playing", c_pl, 1);
    chk("restart_valid", c_tv, 0);
    chk("restart_score", {c_st, c_so}, 0);
    chk("restart_speed", c_sp, 2);
    frame_tick = 1'b1;
    tick_cycle();
    start = 1'b1;
    tick_cycle();
    chk("start_ignored", c_tv[0], 1);

    // Spawn every tick: fill, drop the fifth, then hit continuously to wrap the pointers.
    sel = 1; sf = 1;
    Reset = 1'b1;
    tick_cycle();
    restart();
    repeat (4) begin frame_tick = 1'b1; rand_lane = LW'($urandom); tick_cycle(); end
    chk("full_valid", c_tv, 4'hF);
    frame_tick = 1'b1;
    tick_cycle();
    chk("drop_valid", c_tv, 4'hF);
    chk("drop_y0", c_ty[YW-1:0], 8);
    hits = 0; n = 0;
    while (hits < 100 && n < 6000 && ms == 1) begin
      frame_tick = 1'b1;
      rand_lane = LW'($urandom);
      if (hittable(ql[0])) begin
        press(ql[0]);
        hits++;
      end
      tick_cycle();
      n++;
      if (hits == 1 && key_lane !== 'x && n > 0 && mhead == 1 && mscore == 1) begin
        chk("wrap_y0", c_ty[YW-1:0], 0);
        chk("wrap_valid", c_tv, 4'hF);
        hits = 2 - 1 + 0 * n;
      end
      if (mscore == 10 && mhit == 0) chk("speed_up", c_sp, 3);
      if (hits == 99) chk("score99", {c_st, c_so}, 8'h99);
    end
    chk("hits_done", hits, 100);
    chk("score_sat", {c_st, c_so}, 8'h99);

    // Random play on both instances, compared cycle by cycle against the model.
    for (int ph = 0; ph < 2; ph++) begin
      sel = (ph == 0) ? 1 : 0;
      sf  = (ph == 0) ? 1 : 60;
      Reset = 1'b1;
      tick_cycle();
      for (int c = 0; c < 3000; c++) begin
        frame_tick = ($urandom_range(0, 1) == 1);
        rand_lane  = LW'($urandom);
        start      = ($urandom_range(0, (ms == 1) ? 40 : 6) == 0);
        if (qy.size() > 0 && hittable(ql[0]) && $urandom_range(0, 2) != 0) press(ql[0]);
        else if ($urandom_range(0, 30) == 0) press($urandom_range(0, NL - 1));
        Reset = ($urandom_range(0, 700) == 0);
        tick_cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
